sram_wr_port_sched: RTL and testbench

Write-port scheduler and initialiser for the 5-write-port register-file SRAM.
- Shares the 5 SRAM write ports among NUM_REQ writeback requesters using round-robin arbitration and a valid/ready handshake.
- After reset, sequences a zero-fill of entries INIT_BASE..SRAM_DEPTH-1 before accepting any traffic.
- Sits between the writeback/rename logic and the SRAM write ports; all SRAM-facing outputs are registered.

---
 rtl/sram_sched_pkg.sv | 27 ++
 rtl/sram_wr_grant_slice.sv | 48 ++++
 rtl/sram_wr_port_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_sram_wr_port_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sched_pkg.sv
// ============================================================================
// Module      : sram_sched_pkg
// Description : Shared constants, state encoding and helpers for the SRAM
//               write-port scheduler and its grant slices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_sched_pkg;

    // Number of physical SRAM write ports shared by the requesters
    localparam int NUM_WR = 5;

    // Scheduler states: zero-fill sweep, then normal arbitration
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Index increment that wraps back to zero at n
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wr_grant_slice.sv
// ============================================================================
// Module      : sram_wr_grant_slice
// Description : One combinational grant step. Scans the remaining valid
//               requesters from the start pointer (with wrap-around) and
//               picks the first one whose address is not already claimed by
//               an earlier grant in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wr_grant_slice
    import sram_sched_pkg::*;
#(
    parameter int NUM_REQ    = 8,
    parameter int SRAM_INDEX = 4,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_REQ-1:0]            i_rem_valid,
    input  logic [IDX_W-1:0]              i_start,
    input  logic [NUM_REQ*SRAM_INDEX-1:0] i_req_addr,
    input  logic [(1<<SRAM_INDEX)-1:0]    i_used_addr,
    output logic [NUM_REQ-1:0]            o_pick,
    output logic [IDX_W-1:0]              o_idx,
    output logic                          o_found
);

    // Priority scan from i_start; first eligible requester wins
    always_comb begin
        logic [IDX_W-1:0]      cur;
        logic [SRAM_INDEX-1:0] cur_addr;
        o_pick  = '0;
        o_idx   = '0;
        o_found = 1'b0;
        cur     = i_start;
        for (int k = 0; k < NUM_REQ; k++) begin
            cur_addr = i_req_addr[cur*SRAM_INDEX +: SRAM_INDEX];
            if (!o_found && i_rem_valid[cur] && !i_used_addr[cur_addr]) begin
                o_found     = 1'b1;
                o_pick[cur] = 1'b1;
                o_idx       = cur;
            end
            cur = IDX_W'(wrap_inc(int'(cur), NUM_REQ));
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_wr_port_sched.sv
// ============================================================================
// Module      : sram_wr_port_sched
// Description : Write-port scheduler and initialiser for a 5-write-port
//               register-file SRAM. After reset it zero-fills entries
//               INIT_BASE..SRAM_DEPTH-1, then shares the 5 write ports among
//               NUM_REQ requesters with round-robin arbitration, skipping
//               same-address collisions within a cycle. All SRAM-facing
//               outputs are registered (1-cycle latency).
//               Optional macro WR_SCHED_STALL_CNT_EN builds a 16-bit
//               saturating stall counter on stall_cnt_o (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wr_port_sched
    import sram_sched_pkg::*;
#(
    parameter int SRAM_DEPTH = 16,
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_REQ    = 8,
    parameter int INIT_BASE  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*SRAM_INDEX-1:0] req_addr_i,
    input  logic [NUM_REQ*SRAM_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          we0_o,
    output logic                          we1_o,
    output logic                          we2_o,
    output logic                          we3_o,
    output logic                          we4_o,
    output logic [SRAM_INDEX-1:0]         addr0wr_o,
    output logic [SRAM_INDEX-1:0]         addr1wr_o,
    output logic [SRAM_INDEX-1:0]         addr2wr_o,
    output logic [SRAM_INDEX-1:0]         addr3wr_o,
    output logic [SRAM_INDEX-1:0]         addr4wr_o,
    output logic [SRAM_WIDTH-1:0]         data0wr_o,
    output logic [SRAM_WIDTH-1:0]         data1wr_o,
    output logic [SRAM_WIDTH-1:0]         data2wr_o,
    output logic [SRAM_WIDTH-1:0]         data3wr_o,
    output logic [SRAM_WIDTH-1:0]         data4wr_o,
    output logic                          init_done_o,
    output logic [15:0]                   stall_cnt_o
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = $clog2(SRAM_DEPTH + INIT_BASE + NUM_WR + 1) + 1;
    localparam int ASPACE = 1 << SRAM_INDEX;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       init_ptr_q, init_ptr_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_WR-1:0]      we_q, we_d;
    logic [SRAM_INDEX-1:0]  addr_q [NUM_WR];
    logic [SRAM_INDEX-1:0]  addr_d [NUM_WR];
    logic [SRAM_WIDTH-1:0]  data_q [NUM_WR];
    logic [SRAM_WIDTH-1:0]  data_d [NUM_WR];

    logic [NUM_REQ-1:0]     pick_all  [NUM_WR];
    logic [IDX_W-1:0]       pick_idx  [NUM_WR];
    logic [SRAM_INDEX-1:0]  pick_addr [NUM_WR];
    logic [SRAM_WIDTH-1:0]  pick_data [NUM_WR];
    logic [NUM_WR-1:0]      found;

    // Arbitration is only live in RUN; during INIT nothing can be picked
    logic [NUM_REQ-1:0]     valid_run;
    assign valid_run = (state_q == ST_RUN) ? req_valid_i : '0;

    // Chain of grant slices: each removes its pick from the valid mask and
    // claims the picked address so later slices skip same-address requesters
    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_slice
            logic [NUM_REQ-1:0] rem_in;
            logic [NUM_REQ-1:0] rem_out;
            logic [ASPACE-1:0]  used_in;
            logic [ASPACE-1:0]  used_out;

            if (j == 0) begin : g_first
                assign rem_in  = valid_run;
                assign used_in = '0;
            end else begin : g_next
                assign rem_in  = g_slice[j-1].rem_out;
                assign used_in = g_slice[j-1].used_out;
            end

            sram_wr_grant_slice #(
                .NUM_REQ    (NUM_REQ),
                .SRAM_INDEX (SRAM_INDEX),
                .IDX_W      (IDX_W)
            ) u_slice (
                .i_rem_valid (rem_in),
                .i_start     (rr_ptr_q),
                .i_req_addr  (req_addr_i),
                .i_used_addr (used_in),
                .o_pick      (pick_all[j]),
                .o_idx       (pick_idx[j]),
                .o_found     (found[j])
            );

            assign pick_addr[j] = req_addr_i[pick_idx[j]*SRAM_INDEX +: SRAM_INDEX];
            assign pick_data[j] = req_data_i[pick_idx[j]*SRAM_WIDTH +: SRAM_WIDTH];
            assign rem_out      = rem_in & ~pick_all[j];
            assign used_out     = found[j] ? (used_in | (ASPACE'(1) << pick_addr[j])) : used_in;
        end
    endgenerate

    // Ready is the union of all slice picks (never set without valid)
    always_comb begin
        req_ready_o = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            req_ready_o = req_ready_o | pick_all[j];
        end
    end

    // Next-state and next-port computation for INIT sweep and RUN arbitration
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        rr_ptr_d   = rr_ptr_q;
        we_d       = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            addr_d[k] = '0;
            data_d[k] = '0;
        end
        case (state_q)
            ST_INIT: begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (int'(init_ptr_q) + k < SRAM_DEPTH) begin
                        we_d[k]   = 1'b1;
                        addr_d[k] = SRAM_INDEX'(int'(init_ptr_q) + k);
                    end
                end
                init_ptr_d = PTR_W'(int'(init_ptr_q) + NUM_WR);
                if (int'(init_ptr_q) + NUM_WR >= SRAM_DEPTH) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Grants fill ports in scan order; the last one found sets rr_ptr
                for (int j = 0; j < NUM_WR; j++) begin
                    if (found[j]) begin
                        we_d[j]   = 1'b1;
                        addr_d[j] = pick_addr[j];
                        data_d[j] = pick_data[j];
                        rr_ptr_d  = IDX_W'(wrap_inc(int'(pick_idx[j]), NUM_REQ));
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, pointers and registered SRAM port drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= PTR_W'(INIT_BASE);
            rr_ptr_q   <= '0;
            we_q       <= '0;
            for (int k = 0; k < NUM_WR; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rr_ptr_q   <= rr_ptr_d;
            we_q       <= we_d;
            for (int k = 0; k < NUM_WR; k++) begin
                addr_q[k] <= addr_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

`ifdef WR_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count RUN cycles where some valid requester was left waiting
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && (|(req_valid_i & ~req_ready_o)) &&
            (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign init_done_o = (state_q == ST_RUN);

    assign we0_o = we_q[0];
    assign we1_o = we_q[1];
    assign we2_o = we_q[2];
    assign we3_o = we_q[3];
    assign we4_o = we_q[4];

    assign addr0wr_o = addr_q[0];
    assign addr1wr_o = addr_q[1];
    assign addr2wr_o = addr_q[2];
    assign addr3wr_o = addr_q[3];
    assign addr4wr_o = addr_q[4];

    assign data0wr_o = data_q[0];
    assign data1wr_o = data_q[1];
    assign data2wr_o = data_q[2];
    assign data3wr_o = data_q[3];
    assign data4wr_o = data_q[4];

endmodule

`default_nettype wire

// File: tb/tb_sram_wr_port_sched.sv
// ============================================================================
// Module      : tb_sram_wr_port_sched
// Description : Self-checking bench for sram_wr_port_sched. A sequential
//               reference scan predicts ready and port writes; expected port
//               contents are queued when stimulus is applied and popped after
//               the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_wr_port_sched;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int DW    = 8;
    localparam int NR    = 8;
    localparam int NW    = 5;
    localparam int BASE  = 0;

    typedef struct packed {
        logic [NW-1:0]         we;
        logic [NW-1:0][IW-1:0] addr;
        logic [NW-1:0][DW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*IW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              we0, we1, we2, we3, we4;
    logic [IW-1:0]     a0, a1, a2, a3, a4;
    logic [DW-1:0]     d0, d1, d2, d3, d4;
    logic              init_done;
    logic [15:0]       stall_cnt;

    logic [NW-1:0]     we_v;
    logic [IW-1:0]     addr_v [NW];
    logic [DW-1:0]     data_v [NW];

    always #5 clk = ~clk;

    sram_wr_port_sched #(
        .SRAM_DEPTH (DEPTH),
        .SRAM_INDEX (IW),
        .SRAM_WIDTH (DW),
        .NUM_REQ    (NR),
        .INIT_BASE  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .we0_o       (we0),
        .we1_o       (we1),
        .we2_o       (we2),
        .we3_o       (we3),
        .we4_o       (we4),
        .addr0wr_o   (a0),
        .addr1wr_o   (a1),
        .addr2wr_o   (a2),
        .addr3wr_o   (a3),
        .addr4wr_o   (a4),
        .data0wr_o   (d0),
        .data1wr_o   (d1),
        .data2wr_o   (d2),
        .data3wr_o   (d3),
        .data4wr_o   (d4),
        .init_done_o (init_done),
        .stall_cnt_o (stall_cnt)
    );

    assign we_v = {we4, we3, we2, we1, we0};
    assign addr_v[0] = a0;
    assign addr_v[1] = a1;
    assign addr_v[2] = a2;
    assign addr_v[3] = a3;
    assign addr_v[4] = a4;
    assign data_v[0] = d0;
    assign data_v[1] = d1;
    assign data_v[2] = d2;
    assign data_v[3] = d3;
    assign data_v[4] = d4;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_state;
    int          m_ptr;
    int          m_rr;
    int          m_stall;
    exp_t        sb_q[$];
    logic [7:0]  last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = BASE;
        m_rr    = 0;
        m_stall = 0;
        sb_q.delete();
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_addr[i*IW +: IW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic clr_req();
        req_valid = '0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge
    task automatic step();
        exp_t          e;
        exp_t          got_e;
        logic [NR-1:0] er;
        logic [15:0]   used;
        logic [IW-1:0] a;
        int            cnt;
        int            idx;
        int            last;
        int            nxt_state;
        e    = '0;
        er   = '0;
        used = '0;
        cnt  = 0;
        last = -1;
        nxt_state = m_state;
        #1;
        if (m_state == 0) begin
            for (int k = 0; k < NW; k++) begin
                if (m_ptr + k < DEPTH) begin
                    e.we[k]   = 1'b1;
                    e.addr[k] = IW'(m_ptr + k);
                end
            end
            if (m_ptr + NW >= DEPTH) nxt_state = 1;
            m_ptr = m_ptr + NW;
        end else begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                a   = req_addr[idx*IW +: IW];
                if (req_valid[idx] && cnt < NW && !used[a]) begin
                    er[idx]     = 1'b1;
                    used[a]     = 1'b1;
                    e.we[cnt]   = 1'b1;
                    e.addr[cnt] = a;
                    e.data[cnt] = req_data[idx*DW +: DW];
                    cnt++;
                    last = idx;
                end
            end
            if (last >= 0) m_rr = (last + 1) % NR;
            if (|(req_valid & ~er) && m_stall < 16'hFFFF) m_stall++;
        end
        check("ready", 32'(req_ready), 32'(er));
        last_ready = req_ready;
        sb_q.push_back(e);
        m_state = nxt_state;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            got_e = sb_q.pop_front();
            check("we", 32'(we_v), 32'(got_e.we));
            for (int k = 0; k < NW; k++) begin
                if (got_e.we[k]) begin
                    check($sformatf("port%0d", k), {20'd0, addr_v[k], data_v[k]},
                          {20'd0, got_e.addr[k], got_e.data[k]});
                end
            end
        end
        check("init_done", 32'(init_done), 32'(m_state == 1));
`ifdef WR_SCHED_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`else
        check("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_we", 32'(we_v), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        for (int k = 0; k < NW; k++) begin
            check("rst_port", {20'd0, addr_v[k], data_v[k]}, 32'd0);
        end
        rst = 1'b0;

        // Init sweep with a pending request that must not be granted
        set_req(3, 4'd5, 8'h33);
        repeat (4) step();
        check("init_last_we", 32'(we_v), 32'h01);
        check("init_last_addr", 32'(addr_v[0]), 32'd15);
        check("init_done_rise", 32'(init_done), 32'd1);

        // Full load from rr_ptr=0, then continuation from rr_ptr=5
        clr_req();
        for (int i = 0; i < NR; i++) set_req(i, IW'(i + 1), DW'(8'hA0 + i));
        step();
        check("full_ready", 32'(last_ready), 32'h1F);
        check("full_port4", {20'd0, addr_v[4], data_v[4]}, {20'd0, 4'd5, 8'hA4});
        for (int i = 0; i < NW; i++) set_req(i, IW'(i + 1), DW'(8'hB0 + i));
        step();
        check("full_ready2", 32'(last_ready), 32'hE3);
        check("full2_port0", {20'd0, addr_v[0], data_v[0]}, {20'd0, 4'd6, 8'hA5});

        // Bring rr_ptr back to 0
        clr_req();
        set_req(7, 4'hF, 8'h77);
        step();

        // Same-address conflict between req2 and req5
        clr_req();
        set_req(2, 4'd7, 8'h22);
        set_req(5, 4'd7, 8'h55);
        step();
        check("conflict_ready", 32'(last_ready), 32'h04);
        check("conflict_port0", {20'd0, addr_v[0], data_v[0]}, {20'd0, 4'd7, 8'h22});
        clr_req();
        set_req(5, 4'd7, 8'h55);
        step();
        check("conflict_retry", 32'(last_ready), 32'h20);
        check("conflict_port0b", {20'd0, addr_v[0], data_v[0]}, {20'd0, 4'd7, 8'h55});

        // Move rr_ptr to 7, then wrap-around fairness
        clr_req();
        set_req(6, 4'd3, 8'h66);
        step();
        clr_req();
        set_req(7, 4'h9, 8'h97);
        set_req(0, 4'hA, 8'h0A);
        step();
        check("fair_ready", 32'(last_ready), 32'h81);
        check("fair_port0", {20'd0, addr_v[0], data_v[0]}, {20'd0, 4'h9, 8'h97});
        check("fair_port1", {20'd0, addr_v[1], data_v[1]}, {20'd0, 4'hA, 8'h0A});
        clr_req();
        set_req(0, 4'h1, 8'h01);
        set_req(1, 4'h2, 8'h12);
        step();
        check("fair_rr1", {20'd0, addr_v[0], data_v[0]}, {20'd0, 4'h2, 8'h12});

        // Reset mid-RUN while all five write enables are high
        clr_req();
        for (int i = 0; i < NR; i++) set_req(i, IW'(i + 1), DW'(8'hC0 + i));
        step();
        check("pre_reset_we", 32'(we_v), 32'h1F);
        rst = 1'b1;
        #1;
        check("reset_async_we", 32'(we_v), 32'd0);
        check("reset_async_done", 32'(init_done), 32'd0);
        clr_req();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("reinit_first", {20'd0, addr_v[0], data_v[0]}, {20'd0, 4'd0, 8'h00});
        repeat (3) step();
        check("reinit_done", 32'(init_done), 32'd1);

        // Six distinct requests held for three cycles
        for (int i = 0; i < 6; i++) set_req(i, IW'(i + 1), DW'(8'hD0 + i));
        repeat (3) step();
`ifdef WR_SCHED_STALL_CNT_EN
        check("stall_three", 32'(stall_cnt), 32'd3);
`else
        check("stall_off", 32'(stall_cnt), 32'd0);
`endif

        clr_req();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
